// File: rtl/mdu_e_if.sv
// ---------------------------------------------------------------------------
// mdu_e_if
//   Bundle between the execute stage and the multiply/divide unit.
//   master : pipeline side (drives op request, mthi/mtlo, flush)
//   slave  : mdu_e side (returns busy, done and the HI/LO registers)
//   Signals:
//     flush_e     abort in-flight operation
//     start, op   launch request and opcode (00 mult, 01 multu, 10 div, 11 divu)
//     srca, srcb  rs / rt operands
//     mthi, mtlo  direct writes of srca into HI / LO
//     busy, done  unit occupied / one-cycle result pulse
//     hi, lo      architectural HI / LO registers
// ---------------------------------------------------------------------------
interface mdu_e_if #(
  parameter int WIDTH = 32
);
  logic             flush_e;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush_e, start, op, srca, srcb, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  flush_e, start, op, srca, srcb, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_e.sv
// ---------------------------------------------------------------------------
// mdu_e
//   Execute-stage iterative multiply/divide unit with HI/LO registers.
//   Fixed latency: PREP (1) + RUN (WIDTH) + FIX (1) cycles, one radix-2
//   step per RUN cycle, so the hazard unit can stall on busy alone.
//   Ports:
//     clk   clock, all state updates on posedge
//     clr   asynchronous active-high reset
//     bus   mdu_e_if slave modport (see mdu_e_if for signal list)
// ---------------------------------------------------------------------------
module mdu_e #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    clr,
  mdu_e_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;       // op[1]: divide, op[0]: unsigned
  logic [WIDTH-1:0]    a_q, a_d;         // raw srca, kept for divide-by-zero HI
  logic [WIDTH-1:0]    b_q, b_d;         // raw srcb, replaced by |srcb| in PREP
  logic [2*WIDTH-1:0]  acc_q, acc_d;     // mult: {partial, multiplier}; div: low half = quotient
  logic [WIDTH-1:0]    rem_q, rem_d;     // restoring-divide partial remainder
  logic [CW-1:0]       count_q, count_d;
  logic                qneg_q, qneg_d;   // negate product / quotient
  logic                rneg_q, rneg_d;   // negate remainder
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Datapath helpers, pure functions of the current state.
  logic                is_signed;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic                div_fits;
  logic [WIDTH-1:0]    div_diff;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_fix, rem_fix;

  assign is_signed = ~op_q[0];
  assign a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier LSB is set; the carry becomes the new MSB after the shift.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

  // Restoring divide: bring in the next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so WIDTH+1 bits suffice here.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, b_q});
  assign div_diff  = WIDTH'(div_shift - {1'b0, b_q});

  assign prod_fix  = qneg_q ? -acc_q : acc_q;
  assign quo_fix   = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = rneg_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below leaves one unassigned, which would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    count_d = count_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A start coinciding with flush_e is dropped, not queued.
          if (!bus.flush_e) begin
            op_d    = bus.op;
            a_d     = bus.srca;
            b_d     = bus.srcb;
            state_d = PREP;
          end
        end else begin
          if (bus.mthi) hi_d = bus.srca;
          if (bus.mtlo) lo_d = bus.srca;
        end
      end

      PREP: begin
        acc_d   = {{WIDTH{1'b0}}, a_mag};
        b_d     = b_mag;
        rem_d   = '0;
        count_d = '0;
        qneg_d  = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = is_signed & a_q[WIDTH-1];
        state_d = RUN;
      end

      RUN: begin
        if (op_q[1]) begin
          rem_d = div_fits ? div_diff : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_fits};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FIX;
      end

      FIX: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          // Divide by zero: no trap, LO all ones, HI the untouched dividend.
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // An abort wins over everything, including the FIX write-back.
    if (bus.flush_e && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above, regardless of ordering.
  // NOTE: every register, datapath included, is cleared by clr so the
  // unit leaves reset in a fully defined state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
